// File: rtl/alu_op_encoder.sv
// Encodes semantic ALU requests into {ALUOp, opType} fields and buffers them
// in a DEPTH-entry FIFO; illegal requests are consumed, flagged and counted.
module alu_op_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               req_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               ALUOp,
  output logic [1:0]               opType,
  output logic                     illegal,
  output logic [CNT_W-1:0]         illegal_cnt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = DEPTH[PW:0];

  logic [4:0]       mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  logic       enc_legal;
  logic [4:0] enc_field;
  logic       accept, push, pop;

  always_comb begin
    enc_legal = 1'b1;
    enc_field = '0;
    case (req_op)
      4'd0:    enc_field = 5'b000_00;
      4'd1:    enc_field = 5'b000_01;
      4'd2:    enc_field = 5'b000_10;
      4'd3:    enc_field = 5'b000_11;
      4'd4:    enc_field = 5'b001_00;
      4'd5:    enc_field = 5'b010_00;
      4'd6:    enc_field = 5'b011_00;
      4'd7:    enc_field = 5'b100_00;
      4'd8:    enc_field = 5'b101_00;
      4'd9:    enc_field = 5'b110_00;
      4'd10:   enc_field = 5'b111_00;
      4'd11:   enc_field = 5'b111_01;
      4'd12:   enc_field = 5'b111_10;
      default: enc_legal = 1'b0;
    endcase
  end

  // Ready depends on occupancy alone, so a pop never opens a slot in the same cycle.
  assign req_ready = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign accept    = req_valid && req_ready;
  assign push      = accept && enc_legal;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    illegal_d     = accept && !enc_legal;
    illegal_cnt_d = illegal_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (accept && !enc_legal && (illegal_cnt_q != '1))
      illegal_cnt_d = illegal_cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      illegal_q     <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      illegal_q     <= illegal_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_field;
  end

  assign ALUOp       = out_valid ? mem_q[rd_ptr_q][4:2] : '0;
  assign opType      = out_valid ? mem_q[rd_ptr_q][1:0] : '0;
  assign illegal     = illegal_q;
  assign illegal_cnt = illegal_cnt_q;
  assign count       = count_q;

endmodule

// File: tb/tb_alu_op_encoder.sv
// Randomised and directed bench for alu_op_encoder against a queue-based
// model of the request stream, including an ALU-control round-trip check.
module tb_alu_op_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       req_valid, req_ready, out_valid, out_ready, illegal;
  logic [3:0] req_op;
  logic [2:0] ALUOp;
  logic [1:0] opType;
  logic [CNT_W-1:0] illegal_cnt;
  logic [$clog2(DEPTH):0] count;

  int tests = 0;
  int fails = 0;

  alu_op_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .out_valid(out_valid), .out_ready(out_ready),
    .ALUOp(ALUOp), .opType(opType), .illegal(illegal),
    .illegal_cnt(illegal_cnt), .count(count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Field encoding of each legal semantic op.
  function automatic int enc(input int op);
    case (op)
      0: return 5'b000_00;  1: return 5'b000_01;  2: return 5'b000_10;
      3: return 5'b000_11;  4: return 5'b001_00;  5: return 5'b010_00;
      6: return 5'b011_00;  7: return 5'b100_00;  8: return 5'b101_00;
      9: return 5'b110_00; 10: return 5'b111_00; 11: return 5'b111_01;
      default: return 5'b111_10;
    endcase
  endfunction

  // ALU function each op must produce; -1 means no function asserted.
  function automatic int alu_fn(input int op);
    case (op)
      4, 11: return 1;
      5: return 2;  6: return 3;  1: return 4;  2: return 5;  3: return 6;
      9: return -1;
      default: return 0;
    endcase
  endfunction

  // ALU control decoder consuming the encoded fields.
  function automatic int decode(input int a, input int t);
    case (a)
      0: case (t) 0: return 0; 1: return 4; 2: return 5; default: return 6; endcase
      1: return 1;  2: return 2;  3: return 3;
      4, 5: return 0;
      6: return -1;
      default: case (t) 0: return 0; 1: return 1; 2: return 0; default: return -7; endcase
    endcase
  endfunction

  int mq[$];
  int m_ill, m_cnt;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mq.delete();
      m_ill <= 0;
      m_cnt <= 0;
    end else begin
      automatic bit acc  = req_valid && (mq.size() < DEPTH);
      automatic bit pop  = (mq.size() != 0) && out_ready;
      automatic bit lgl  = (req_op <= 4'd12);
      m_ill <= (acc && !lgl) ? 1 : 0;
      if (acc && !lgl && m_cnt != MAXC) m_cnt <= m_cnt + 1;
      if (pop) void'(mq.pop_front());
      if (acc && lgl) mq.push_back(int'(req_op));
    end
  end

  always @(negedge Clk) begin
    if (Reset) begin
      check("req_ready", int'(req_ready), (mq.size() < DEPTH) ? 1 : 0);
      check("out_valid", int'(out_valid), (mq.size() != 0) ? 1 : 0);
      check("count", int'(count), mq.size());
      check("illegal", int'(illegal), m_ill);
      check("illegal_cnt", int'(illegal_cnt), m_cnt);
      if (mq.size() != 0) begin
        check("fields", int'({ALUOp, opType}), enc(mq[0]));
        check("roundtrip", decode(int'(ALUOp), int'(opType)), alu_fn(mq[0]));
      end else begin
        check("fields_empty", int'({ALUOp, opType}), 0);
      end
    end
  end

  task automatic drive(input bit v, input int op, input bit rdy);
    req_valid = v;
    req_op    = op[3:0];
    out_ready = rdy;
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic do_reset();
    #3 Reset = 1'b0;
    #1;
    check("rst_count", int'(count), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_fields", int'({ALUOp, opType}), 0);
    check("rst_illegal", int'(illegal), 0);
    check("rst_illegal_cnt", int'(illegal_cnt), 0);
    check("rst_req_ready", int'(req_ready), 1);
    @(negedge Clk);
    #1 Reset = 1'b1;
    step();
  endtask

  initial begin
    Reset = 1'b0;
    drive(0, 0, 0);
    #2;
    check("init_count", int'(count), 0);
    check("init_req_ready", int'(req_ready), 1);
    #10 Reset = 1'b1;
    step();

    // Back-to-back legal ops with the consumer always ready.
    for (int i = 0; i <= 12; i++) begin
      drive(1, i, 1);
      step();
      check("b2b_count_le1", (count <= 1) ? 1 : 0, 1);
      check("b2b_valid", int'(out_valid), 1);
      if (i == 2)  check("b2b_xorr", int'({ALUOp, opType}), 5'b000_10);
      if (i == 9)  check("b2b_jump", int'({ALUOp, opType}), 5'b110_00);
      if (i == 12) check("b2b_swap", int'({ALUOp, opType}), 5'b111_10);
    end
    drive(0, 0, 1);
    step();

    // Fill to full, single pop, then delayed acceptance of the fifth op.
    for (int i = 0; i < 4; i++) begin
      drive(1, i + 4, 0);
      step();
    end
    check("full_count", int'(count), 4);
    check("full_ready", int'(req_ready), 0);
    drive(1, 8, 1);
    step();
    check("pop_in_full_count", int'(count), 3);
    drive(1, 8, 0);
    step();
    check("fifth_accepted", int'(count), 4);
    drive(0, 0, 1);
    repeat (5) step();

    // Illegal op between ADD and SLL.
    do_reset();
    drive(1, 0, 1);  step();
    drive(1, 14, 1); step();
    check("ill_pulse", int'(illegal), 1);
    check("ill_empty", int'(out_valid), 0);
    drive(1, 6, 1);  step();
    check("ill_pulse_end", int'(illegal), 0);
    check("ill_sll", int'({ALUOp, opType}), 5'b011_00);
    check("ill_cnt1", int'(illegal_cnt), 1);
    drive(0, 0, 1);  step();

    // Saturation of the illegal counter.
    for (int i = 0; i < 300; i++) begin
      drive(1, 13 + (i % 3), 1);
      step();
    end
    check("sat_cnt", int'(illegal_cnt), 255);
    check("sat_empty", int'(count), 0);
    drive(0, 0, 1);
    step();

    // Steady push/pop at occupancy 2.
    drive(1, 1, 0); step();
    drive(1, 3, 0); step();
    for (int i = 0; i < 10; i++) begin
      drive(1, $urandom_range(12), 1);
      step();
      check("steady_count", int'(count), 2);
    end
    drive(0, 0, 1);
    repeat (3) step();

    // Reset mid-pop with three entries buffered.
    for (int i = 0; i < 3; i++) begin
      drive(1, 7 + i, 0);
      step();
    end
    drive(0, 0, 1);
    do_reset();
    drive(1, 6, 1);
    step();
    check("post_rst_sll", int'({ALUOp, opType}), 5'b011_00);
    drive(0, 0, 1);
    step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(3) != 0, $urandom_range(15), $urandom_range(2) != 0);
      step();
    end
    drive(0, 0, 1);
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
